delay_v_var: RTL and testbench

//  Vector delay line: LENGTH lanes of WIDTH bits, with a valid tag and a run-time-selectable

---
 rtl/delay_v_pkg.sv | 21 ++
 rtl/delay_v_ram.sv | 32 +++
 rtl/delay_v_var.sv | 114 +++++++++++
 tb/tb_delay_v_var.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/delay_v_pkg.sv
// Shared types and sizing helpers for the variable vector delay line.
// Used by delay_v_var (optional feature macro: DELAY_V_VAR_ZERO_INVALID_EN).
package delay_v_pkg;

  typedef enum logic {FILL, RUN} dly_state_t;

  function automatic int dly_w(input int max);
    return $clog2(max + 1);
  endfunction

  function automatic int ptr_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

  function automatic int clamp_delay(input int sel, input int max);
    if (sel < 1) return 1;
    if (sel > max) return max;
    return sel;
  endfunction

endpackage

// File: rtl/delay_v_ram.sv
// Circular sample store with registered, read-before-write read port.
// Storage is unreset; only the read register clears on reset.
module delay_v_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) mem_q[waddr_i] <= wdata_i;
  end

  // Nonblocking write makes a same-address read return the old word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else if (en_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_v_var.sv
// Vector delay line with run-time delay 1..MAX_DELAY and valid tags.
// Define DELAY_V_VAR_ZERO_INVALID_EN to force c to zero when c_valid=0.
module delay_v_var
  import delay_v_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int LENGTH    = 4,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = dly_w(MAX_DELAY)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [DW-1:0]                delay_sel,
  input  logic [LENGTH-1:0][WIDTH-1:0] a,
  input  logic                         a_valid,
  output logic [LENGTH-1:0][WIDTH-1:0] c,
  output logic                         c_valid,
  output logic                         ready
);

  localparam int AW = ptr_w(MAX_DELAY);
  localparam int BW = WIDTH * LENGTH;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_idx;
  logic [DW-1:0]        fill_q, fill_d;
  logic [DW-1:0]        cur_q, cur_d;
  logic [DW-1:0]        new_dly;
  logic [MAX_DELAY-1:0] tag_q, tag_d;
  dly_state_t           state_q, state_d;
  logic                 cv_q, cv_d;
  logic                 chg;
  logic [BW-1:0]        rdata;
  int                   rd_i;

  always_comb begin
    new_dly = DW'(clamp_delay(int'(delay_sel), MAX_DELAY));
    chg     = en && (new_dly != cur_q);
  end

  always_comb begin
    rd_i = int'(wr_ptr_q) - int'(cur_q);
    if (rd_i < 0) rd_i = rd_i + MAX_DELAY;
    rd_idx = AW'(rd_i);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    cur_d    = cur_q;
    tag_d    = tag_q;
    state_d  = state_q;
    cv_d     = cv_q;
    if (en) begin
      wr_ptr_d = (wr_ptr_q == AW'(MAX_DELAY - 1))
               ? '0 : wr_ptr_q + AW'(1);
      cv_d = tag_q[rd_idx] && (state_q == RUN) && !chg;
      if (chg) begin
        cur_d  = new_dly;
        tag_d  = '0;
        fill_d = DW'(1);
      end else if (state_q == FILL) begin
        fill_d = fill_q + DW'(1);
      end
      tag_d[wr_ptr_q] = a_valid;
      // Primed once as many samples as the delay are stored.
      if (chg || state_q == FILL)
        state_d = (fill_d >= cur_d) ? RUN : FILL;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      cur_q    <= DW'(1);
      tag_q    <= '0;
      state_q  <= FILL;
      cv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      cur_q    <= cur_d;
      tag_q    <= tag_d;
      state_q  <= state_d;
      cv_q     <= cv_d;
    end
  end

  delay_v_ram #(
    .DEPTH  (MAX_DELAY),
    .DATA_W (BW),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (en),
    .waddr_i (wr_ptr_q),
    .wdata_i (a),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  assign c_valid = cv_q;
  assign ready   = (state_q == RUN);

`ifdef DELAY_V_VAR_ZERO_INVALID_EN
  assign c = cv_q ? rdata : '0;
`else
  assign c = rdata;
`endif

endmodule

// File: tb/tb_delay_v_var.sv
// Randomized bench for delay_v_var against a sample-history model.
// Honours DELAY_V_VAR_ZERO_INVALID_EN when checking c on invalid cycles.
module tb_delay_v_var;

  localparam int MAXD = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             a_valid = 1'b0;
  logic [4:0]       delay_sel = '0;
  logic [3:0][7:0]  a = '0;
  logic [3:0][7:0]  c;
  logic             c_valid;
  logic             ready;

  delay_v_var dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .delay_sel (delay_sel),
    .a         (a),
    .a_valid   (a_valid),
    .c         (c),
    .c_valid   (c_valid),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          v;
    int          ep;
  } smp_t;

  smp_t        hist[$];
  int          ep = 0;
  int          m_cur = 1;
  int          m_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          x_cv, x_rdy, x_ck;
  logic [31:0] x_c;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampd(input int s);
    return (s < 1) ? 1 : ((s > MAXD) ? MAXD : s);
  endfunction

  task automatic m_reset();
    hist.delete();
    ep++;
    m_cur = 1;
    m_cnt = 0;
    x_cv  = 1'b0;
    x_rdy = 1'b0;
    x_c   = '0;
    x_ck  = 1'b1;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".c_valid"}, 32'(c_valid), 32'(x_cv));
    chk({tag, ".ready"}, 32'(ready), 32'(x_rdy));
    if (x_ck) chk({tag, ".c"}, c, x_c);
  endtask

  // Each enabled edge appends one sample; output is the sample D edges back
  // provided it belongs to the current delay epoch.
  task automatic step(input string tag, input bit e, input int s,
                      input logic [31:0] d, input bit v);
    en        = e;
    delay_sel = 5'(s);
    a         = d;
    a_valid   = v;
    @(posedge clk);
    if (e) begin
      int   dd;
      int   idx;
      smp_t sm;
      dd = clampd(s);
      if (dd != m_cur) begin
        ep++;
        m_cur = dd;
        m_cnt = 0;
      end
      sm.d = d;
      sm.v = v;
      sm.ep = ep;
      hist.push_back(sm);
      m_cnt++;
      if (hist.size() > 64) void'(hist.pop_front());
      idx = hist.size() - 1 - dd;
      if (idx >= 0 && hist[idx].ep == ep) begin
        x_cv = hist[idx].v;
        x_c  = hist[idx].d;
      end else begin
        x_cv = 1'b0;
      end
      x_rdy = (m_cnt >= dd);
`ifdef DELAY_V_VAR_ZERO_INVALID_EN
      x_ck = 1'b1;
      if (!x_cv) x_c = '0;
`else
      x_ck = x_cv;
`endif
    end
    #1;
    check_out(tag);
  endtask

  initial begin
    int s;
    m_reset();
    #12;
    check_out("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 30; n++)
      step("ramp_d5", 1'b1, 5,
           {8'(n + 3), 8'(n + 2), 8'(n + 1), 8'(n)}, 1'b1);

    for (int n = 0; n < 56; n++)
      step("wrap_d16", 1'b1, 16, $urandom, 1'b1);

    for (int n = 0; n < 20; n++)
      step("run_d4", 1'b1, 4, $urandom, 1'b1);
    for (int n = 0; n < 20; n++)
      step("chg_d7", 1'b1, 7, $urandom, 1'b1);

    for (int n = 0; n < 24; n++)
      step("stall_d3", (n % 4 == 0) || (n % 4 == 3), 3, $urandom,
           1'($urandom_range(0, 3) != 0));

    for (int n = 0; n < 20; n++)
      step("sel0", 1'b1, 0, $urandom, 1'($urandom_range(0, 1)));
    for (int n = 0; n < 40; n++)
      step("sel31", 1'($urandom_range(0, 3) != 0), 31, $urandom,
           1'($urandom_range(0, 1)));

    for (int n = 0; n < 12; n++)
      step("pre_rst", 1'b1, 6, $urandom, 1'b1);
    #2;
    rstn = 1'b0;
    m_reset();
    #1;
    check_out("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 20; n++)
      step("post_rst", 1'b1, 6, $urandom, 1'b1);

    s = $urandom_range(0, 20);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) s = $urandom_range(0, 20);
      step("rand", 1'($urandom_range(0, 3) != 0), s, $urandom,
           1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
